// File: rtl/apb_master_bridge_if.sv
`default_nettype none
// ============================================================================
// Module      : apb_master_bridge_if
// Description : Bundles the request side and the APB bus side of the
//               apb_master_bridge.
//               master modport : the bridge's view
//               slave  modport : the requester / slave-fabric view
//   Request : transfer, mpwrite, apb_write_paddr, apb_write_data,
//             apb_read_paddr, req_ready
//   APB     : paddr, pwrite, pwdata, psel, penable, prdata, pready, pslverr
//   Status  : apb_read_data_out, rd_valid, xfer_done, xfer_err
// Revision    : 1.0 - initial release
// ============================================================================
interface apb_master_bridge_if #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int NUM_SLV = 2
);
  // request side
  logic                      transfer;
  logic                      mpwrite;
  logic [ADDR_W-1:0]         apb_write_paddr;
  logic [DATA_W-1:0]         apb_write_data;
  logic [ADDR_W-1:0]         apb_read_paddr;
  logic                      req_ready;
  // APB side
  logic [ADDR_W-1:0]         paddr;
  logic                      pwrite;
  logic [DATA_W-1:0]         pwdata;
  logic [NUM_SLV-1:0]        psel;
  logic                      penable;
  logic [NUM_SLV*DATA_W-1:0] prdata;
  logic [NUM_SLV-1:0]        pready;
  logic [NUM_SLV-1:0]        pslverr;
  // completion status
  logic [DATA_W-1:0]         apb_read_data_out;
  logic                      rd_valid;
  logic                      xfer_done;
  logic                      xfer_err;

  modport master (
    input  transfer, mpwrite, apb_write_paddr, apb_write_data, apb_read_paddr,
    input  prdata, pready, pslverr,
    output req_ready, paddr, pwrite, pwdata, psel, penable,
    output apb_read_data_out, rd_valid, xfer_done, xfer_err
  );

  modport slave (
    output transfer, mpwrite, apb_write_paddr, apb_write_data, apb_read_paddr,
    output prdata, pready, pslverr,
    input  req_ready, paddr, pwrite, pwdata, psel, penable,
    input  apb_read_data_out, rd_valid, xfer_done, xfer_err
  );
endinterface
`default_nettype wire

// File: rtl/apb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module      : apb_master_bridge
// Description : Parametrised single-outstanding APB master. Accepts one
//               read/write request at a time, decodes the slave from the top
//               SEL_W address bits, runs SETUP/ACCESS with PREADY wait
//               states, reports PSLVERR, aborts on a wait-state timeout and
//               supports back-to-back transfers.
// Ports       : pclk    - clock, rising edge
//               preset  - synchronous active-high reset
//               bus     - apb_master_bridge_if.master (request + APB + status)
// Revision    : 1.0 - initial release
// ============================================================================
module apb_master_bridge #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int NUM_SLV = 2,
  parameter int SEL_W   = 1,
  parameter int TIMEOUT = 15
) (
  input  logic                 pclk,
  input  logic                 preset,
  apb_master_bridge_if.master  bus
);

  localparam int NUM_IDX = 2 ** SEL_W;
  localparam int CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t              state_q,     state_d;
  logic [ADDR_W-1:0]   paddr_q,     paddr_d;
  logic [DATA_W-1:0]   pwdata_q,    pwdata_d;
  logic                pwrite_q,    pwrite_d;
  logic [DATA_W-1:0]   rdata_q,     rdata_d;
  logic                rd_valid_q,  rd_valid_d;
  logic                xfer_done_q, xfer_done_d;
  logic                xfer_err_q,  xfer_err_d;
  logic                dec_pend_q,  dec_pend_d;
  logic [CNT_W-1:0]    wait_cnt_q,  wait_cnt_d;

  // Slave-side inputs padded out to the full decode range so that an
  // out-of-range index reads as "not ready / no error / zero data".
  logic [NUM_IDX-1:0]  pready_ext;
  logic [NUM_IDX-1:0]  pslverr_ext;
  logic [DATA_W-1:0]   prdata_ext [NUM_IDX];

  for (genvar i = 0; i < NUM_IDX; i++) begin : g_pad
    if (i < NUM_SLV) begin : g_real
      assign pready_ext[i]  = bus.pready[i];
      assign pslverr_ext[i] = bus.pslverr[i];
      assign prdata_ext[i]  = bus.prdata[i*DATA_W +: DATA_W];
    end else begin : g_none
      assign pready_ext[i]  = 1'b0;
      assign pslverr_ext[i] = 1'b0;
      assign prdata_ext[i]  = '0;
    end
  end

  logic [SEL_W-1:0]    cur_idx;
  logic [ADDR_W-1:0]   new_addr;
  logic [SEL_W-1:0]    new_idx;
  logic                new_ok;
  logic                cur_ready;
  logic                req_ready;
  logic                accept;
  logic [NUM_IDX-1:0]  psel_full;

  assign cur_idx   = paddr_q[ADDR_W-1 -: SEL_W];
  assign new_addr  = bus.mpwrite ? bus.apb_write_paddr : bus.apb_read_paddr;
  assign new_idx   = new_addr[ADDR_W-1 -: SEL_W];
  assign new_ok    = (32'(new_idx) < NUM_SLV);
  assign cur_ready = pready_ext[cur_idx];
  assign accept    = bus.transfer && req_ready;

  // A decode error accepted back-to-back cannot pulse in the same cycle as
  // the completion it followed, so it is reported one cycle later from IDLE;
  // new requests are held off for that one cycle.
  always_comb begin
    req_ready = 1'b0;
    case (state_q)
      ST_IDLE:   req_ready = !dec_pend_q;
      ST_ACCESS: req_ready = cur_ready;
      default:   req_ready = 1'b0;
    endcase
  end

  always_comb begin
    psel_full = '0;
    if (state_q != ST_IDLE) psel_full[cur_idx] = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pwrite_d    = pwrite_q;
    rdata_d     = rdata_q;
    rd_valid_d  = 1'b0;
    xfer_done_d = 1'b0;
    xfer_err_d  = 1'b0;
    dec_pend_d  = 1'b0;
    wait_cnt_d  = wait_cnt_q;

    if (accept) begin
      paddr_d  = new_addr;
      pwdata_d = bus.apb_write_data;
      pwrite_d = bus.mpwrite;
    end

    case (state_q)
      ST_IDLE: begin
        if (dec_pend_q) begin
          xfer_done_d = 1'b1;
          xfer_err_d  = 1'b1;
        end else if (accept) begin
          if (new_ok) begin
            state_d = ST_SETUP;
          end else begin
            xfer_done_d = 1'b1;
            xfer_err_d  = 1'b1;
          end
        end
      end

      ST_SETUP: begin
        state_d    = ST_ACCESS;
        wait_cnt_d = '0;
      end

      ST_ACCESS: begin
        if (cur_ready) begin
          xfer_done_d = 1'b1;
          xfer_err_d  = pslverr_ext[cur_idx];
          wait_cnt_d  = '0;
          // read data is returned even on a slave error
          if (!pwrite_q) begin
            rdata_d    = prdata_ext[cur_idx];
            rd_valid_d = 1'b1;
          end
          if (accept && new_ok) begin
            state_d = ST_SETUP;
          end else if (accept) begin
            state_d    = ST_IDLE;
            dec_pend_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
          // this cycle is the TIMEOUT-th wait cycle
          if ((TIMEOUT != 0) && ((32'(wait_cnt_q) + 32'd1) == 32'(TIMEOUT))) begin
            xfer_done_d = 1'b1;
            xfer_err_d  = 1'b1;
            wait_cnt_d  = '0;
            state_d     = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q     <= ST_IDLE;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      rdata_q     <= '0;
      rd_valid_q  <= 1'b0;
      xfer_done_q <= 1'b0;
      xfer_err_q  <= 1'b0;
      dec_pend_q  <= 1'b0;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pwrite_q    <= pwrite_d;
      rdata_q     <= rdata_d;
      rd_valid_q  <= rd_valid_d;
      xfer_done_q <= xfer_done_d;
      xfer_err_q  <= xfer_err_d;
      dec_pend_q  <= dec_pend_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  assign bus.req_ready         = req_ready;
  assign bus.paddr             = paddr_q;
  assign bus.pwrite            = pwrite_q;
  assign bus.pwdata            = pwdata_q;
  assign bus.psel              = psel_full[NUM_SLV-1:0];
  assign bus.penable           = (state_q == ST_ACCESS);
  assign bus.apb_read_data_out = rdata_q;
  assign bus.rd_valid          = rd_valid_q;
  assign bus.xfer_done         = xfer_done_q;
  assign bus.xfer_err          = xfer_err_q;

endmodule
`default_nettype wire
